conv_window_3x3: RTL and testbench

Streaming 3x3 sliding-window generator that sits directly upstream of the 3x3 convolution MAC stage. It accepts one raster-order pixel per valid cycle and holds the previous two image rows in line buffers. For every pixel position where a full 3x3 neighbourhood exists, it presents nine registered pixels (win0..win8), ordered to map one-to-one onto the MAC stage's in0..in8.
Operates on unsigned BD-bit pixels. No backpressure: the downstream stage is combinational and always accepts.

---
 rtl/cnn_pkg.sv | 21 ++
 rtl/conv_window_3x3_if.sv | 39 +++
 rtl/line_buffer.sv | 31 +++
 rtl/conv_window_3x3.sv | 128 ++++++++++++
 tb/tb_conv_window_3x3.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared CNN datapath constants, pixel type and counter-width helper
//
// Purpose: defaults shared by the sliding-window generator and the 3x3 MAC stage.
// Ports:   none (package).
package cnn_pkg;

  localparam int CNN_BD    = 16;
  localparam int CNN_IMG_W = 28;
  localparam int CNN_IMG_H = 28;

  // Width of a counter that must reach dim-1; never narrower than one bit.
  function automatic int cnt_width(input int dim);
    return (dim > 1) ? $clog2(dim) : 1;
  endfunction

  localparam int CNN_COL_W = cnt_width(CNN_IMG_W);
  localparam int CNN_ROW_W = cnt_width(CNN_IMG_H);

  typedef logic [CNN_BD-1:0] pixel_t;

endpackage

// File: rtl/conv_window_3x3_if.sv
// rtl/conv_window_3x3_if.sv - pixel stream in / 3x3 window out bundle
//
// Purpose: groups the raster pixel input and the registered window output.
// Ports (signals): in_valid, sof, pixel_in (stream in);
//                  win0..win8, win_valid, win_row, win_col, frame_done (window out).
// Modports: master = pixel source / window consumer, slave = window generator.
interface conv_window_3x3_if
  import cnn_pkg::*;
#(
  parameter int BD    = CNN_BD,
  parameter int IMG_W = CNN_IMG_W,
  parameter int IMG_H = CNN_IMG_H
);
  localparam int COL_W = cnt_width(IMG_W);
  localparam int ROW_W = cnt_width(IMG_H);

  logic             in_valid;
  logic             sof;
  logic [BD-1:0]    pixel_in;

  logic [BD-1:0]    win0, win1, win2, win3, win4, win5, win6, win7, win8;
  logic             win_valid;
  logic [ROW_W-1:0] win_row;
  logic [COL_W-1:0] win_col;
  logic             frame_done;

  modport master (
    output in_valid, sof, pixel_in,
    input  win0, win1, win2, win3, win4, win5, win6, win7, win8,
    input  win_valid, win_row, win_col, frame_done
  );

  modport slave (
    input  in_valid, sof, pixel_in,
    output win0, win1, win2, win3, win4, win5, win6, win7, win8,
    output win_valid, win_row, win_col, frame_done
  );

endinterface

// File: rtl/line_buffer.sv
// rtl/line_buffer.sv - single-port one-row pixel memory, read-before-write
//
// Purpose: holds one image row; the read returns the old word at addr in the
//          same cycle that a write to addr is issued.
// Ports: clk; addr (column); we (write enable); wdata (pixel in); rdata (old pixel out).
module line_buffer
  import cnn_pkg::*;
#(
  parameter int BD    = CNN_BD,
  parameter int DEPTH = CNN_IMG_W,
  parameter int AW    = cnt_width(DEPTH)
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic          we,
  input  logic [BD-1:0] wdata,
  output logic [BD-1:0] rdata
);

  logic [BD-1:0] mem [DEPTH];

  // Asynchronous read gives the pre-write contents of this cycle's address.
  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/conv_window_3x3.sv
// rtl/conv_window_3x3.sv - streaming 3x3 sliding-window generator for the MAC stage
//
// Purpose: accepts raster-order pixels, keeps the previous two rows in line
//          buffers and presents a registered 3x3 neighbourhood for every
//          centre that has all nine neighbours inside the image.
// Ports: clk; rst_n (sync, active low);
//        bus.slave: in_valid, sof, pixel_in -> win0..win8 (row-major),
//        win_valid, win_row/win_col (window centre), frame_done.
module conv_window_3x3
  import cnn_pkg::*;
#(
  parameter int BD    = CNN_BD,
  parameter int IMG_W = CNN_IMG_W,
  parameter int IMG_H = CNN_IMG_H
) (
  input  logic             clk,
  input  logic             rst_n,
  conv_window_3x3_if.slave bus
);

  localparam int COL_W = cnt_width(IMG_W);
  localparam int ROW_W = cnt_width(IMG_H);

  localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
  localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);
  localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  logic [COL_W-1:0] col_cnt, col_pos;
  logic [ROW_W-1:0] row_cnt, row_pos;
  logic [BD-1:0]    lb0_rd, lb1_rd;
  logic [BD-1:0]    win [9];
  logic             win_valid_q, frame_done_q, full_window;
  logic [ROW_W-1:0] win_row_q;
  logic [COL_W-1:0] win_col_q;

  // sof forces the accepted pixel to (0,0) whatever the counters say.
  always_comb begin
    col_pos = col_cnt;
    row_pos = row_cnt;
    if (bus.sof) begin
      col_pos = '0;
      row_pos = '0;
    end
  end

  assign full_window = (row_pos >= ROW_TWO) && (col_pos >= COL_TWO);

  // lb0 holds row r-1; its old word cascades into lb1, which holds row r-2.
  line_buffer #(.BD(BD), .DEPTH(IMG_W), .AW(COL_W)) u_lb0 (
    .clk   (clk),
    .addr  (col_pos),
    .we    (bus.in_valid),
    .wdata (bus.pixel_in),
    .rdata (lb0_rd)
  );

  line_buffer #(.BD(BD), .DEPTH(IMG_W), .AW(COL_W)) u_lb1 (
    .clk   (clk),
    .addr  (col_pos),
    .we    (bus.in_valid),
    .wdata (lb0_rd),
    .rdata (lb1_rd)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_cnt      <= '0;
      row_cnt      <= '0;
      for (int i = 0; i < 9; i++) win[i] <= '0;
      win_valid_q  <= 1'b0;
      win_row_q    <= '0;
      win_col_q    <= '0;
      frame_done_q <= 1'b0;
    end else if (bus.in_valid) begin
      // Each window row shifts left; the new right column is rows r-2, r-1, r.
      win[0] <= win[1];
      win[1] <= win[2];
      win[2] <= lb1_rd;
      win[3] <= win[4];
      win[4] <= win[5];
      win[5] <= lb0_rd;
      win[6] <= win[7];
      win[7] <= win[8];
      win[8] <= bus.pixel_in;

      win_valid_q <= full_window;
      if (full_window) begin
        win_row_q <= row_pos - ROW_ONE;
        win_col_q <= col_pos - COL_ONE;
      end

      frame_done_q <= 1'b0;
      if (col_pos == COL_LAST) begin
        col_cnt <= '0;
        if (row_pos == ROW_LAST) begin
          row_cnt      <= '0;
          frame_done_q <= 1'b1;
        end else begin
          row_cnt <= row_pos + ROW_ONE;
        end
      end else begin
        col_cnt <= col_pos + COL_ONE;
        row_cnt <= row_pos;
      end
    end else begin
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end
  end

  assign bus.win0       = win[0];
  assign bus.win1       = win[1];
  assign bus.win2       = win[2];
  assign bus.win3       = win[3];
  assign bus.win4       = win[4];
  assign bus.win5       = win[5];
  assign bus.win6       = win[6];
  assign bus.win7       = win[7];
  assign bus.win8       = win[8];
  assign bus.win_valid  = win_valid_q;
  assign bus.win_row    = win_row_q;
  assign bus.win_col    = win_col_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_conv_window_3x3.sv
// tb/tb_conv_window_3x3.sv - self-checking bench for conv_window_3x3 (5x4 and 3x3 images)
module tb_conv_window_3x3;

  localparam int BD = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          a_valid, a_sof, b_valid, b_sof;
  logic [BD-1:0] a_pix, b_pix;
  logic          chk_en;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [143:0] flat;
    int           row;
    int           col;
    logic         fd;
  } win_rec_t;

  win_rec_t qa[$];
  win_rec_t qb[$];
  int nfd_a = 0;
  int nfd_b = 0;

  // cfg[0]: 5x4 image, cfg[1]: 3x3 image. Each has its own image-array model.
  for (genvar g = 0; g < 2; g++) begin : cfg
    localparam int W = (g == 0) ? 5 : 3;
    localparam int H = (g == 0) ? 4 : 3;

    conv_window_3x3_if #(.BD(BD), .IMG_W(W), .IMG_H(H)) ifc ();

    conv_window_3x3 #(.BD(BD), .IMG_W(W), .IMG_H(H)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc)
    );

    assign ifc.in_valid = (g == 0) ? a_valid : b_valid;
    assign ifc.sof      = (g == 0) ? a_sof   : b_sof;
    assign ifc.pixel_in = (g == 0) ? a_pix   : b_pix;

    logic [143:0] act_flat;
    assign act_flat = {ifc.win0, ifc.win1, ifc.win2, ifc.win3, ifc.win4,
                       ifc.win5, ifc.win6, ifc.win7, ifc.win8};

    logic [BD-1:0] img [H][W];
    int            mr, mc;
    logic          exp_v, exp_fd, exp_known;
    logic [143:0]  exp_flat;
    int            exp_row, exp_col;

    // Model: place each accepted pixel into a frame image; a window is due
    // whenever the 3x3 block ending at that pixel lies inside the image.
    always @(posedge clk) begin : model
      int r, c, rr, cc;
      logic [143:0] f;
      if (!rst_n) begin
        mr <= 0; mc <= 0;
        exp_v <= 1'b0; exp_fd <= 1'b0; exp_known <= 1'b1;
        exp_flat <= '0; exp_row <= 0; exp_col <= 0;
      end else if (ifc.in_valid) begin
        r = ifc.sof ? 0 : mr;
        c = ifc.sof ? 0 : mc;
        img[r][c] <= ifc.pixel_in;
        exp_fd    <= (r == H - 1) && (c == W - 1);
        exp_v     <= (r >= 2) && (c >= 2);
        exp_known <= (r >= 2) && (c >= 2);
        if (r >= 2 && c >= 2) begin
          f = '0;
          for (int k = 0; k < 9; k++) begin
            rr = r - 2 + k / 3;
            cc = c - 2 + k % 3;
            f = {f[127:0], (rr == r && cc == c) ? ifc.pixel_in : img[rr][cc]};
          end
          exp_flat <= f;
          exp_row  <= r - 1;
          exp_col  <= c - 1;
        end
        if (c == W - 1) begin
          mc <= 0;
          mr <= (r == H - 1) ? 0 : r + 1;
        end else begin
          mc <= c + 1;
          mr <= r;
        end
      end else begin
        exp_v  <= 1'b0;
        exp_fd <= 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [143:0] act, input logic [143:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Window i of a frame with pixel(r,c) = off + r*16 + c and wc windows per row.
  function automatic logic [143:0] win_at(input int off, input int i, input int wc);
    logic [143:0] f;
    int tr, tc;
    f  = '0;
    tr = i / wc;
    tc = i % wc;
    for (int k = 0; k < 9; k++) f = {f[127:0], 16'(off + (tr + k / 3) * 16 + tc + k % 3)};
    return f;
  endfunction

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("a_win_valid",  144'(cfg[0].ifc.win_valid),  144'(cfg[0].exp_v));
        chk("a_frame_done", 144'(cfg[0].ifc.frame_done), 144'(cfg[0].exp_fd));
        chk("a_win_row",    144'(cfg[0].ifc.win_row),    144'(cfg[0].exp_row));
        chk("a_win_col",    144'(cfg[0].ifc.win_col),    144'(cfg[0].exp_col));
        if (cfg[0].exp_known) chk("a_window", cfg[0].act_flat, cfg[0].exp_flat);
        chk("b_win_valid",  144'(cfg[1].ifc.win_valid),  144'(cfg[1].exp_v));
        chk("b_frame_done", 144'(cfg[1].ifc.frame_done), 144'(cfg[1].exp_fd));
        chk("b_win_row",    144'(cfg[1].ifc.win_row),    144'(cfg[1].exp_row));
        chk("b_win_col",    144'(cfg[1].ifc.win_col),    144'(cfg[1].exp_col));
        if (cfg[1].exp_known) chk("b_window", cfg[1].act_flat, cfg[1].exp_flat);
        if (cfg[0].ifc.win_valid)
          qa.push_back('{cfg[0].act_flat, int'(cfg[0].ifc.win_row), int'(cfg[0].ifc.win_col), cfg[0].ifc.frame_done});
        if (cfg[1].ifc.win_valid)
          qb.push_back('{cfg[1].act_flat, int'(cfg[1].ifc.win_row), int'(cfg[1].ifc.win_col), cfg[1].ifc.frame_done});
        if (cfg[0].ifc.frame_done) nfd_a++;
        if (cfg[1].ifc.frame_done) nfd_b++;
      end
    end
  endtask

  task automatic pa(input int p, input logic s);
    @(posedge clk); #1;
    a_valid = 1'b1; a_sof = s; a_pix = 16'(p);
  endtask

  task automatic ia(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      a_valid = 1'b0; a_sof = 1'b0; a_pix = 16'($urandom);
    end
  endtask

  task automatic pb(input int p, input logic s);
    @(posedge clk); #1;
    b_valid = 1'b1; b_sof = s; b_pix = 16'(p);
  endtask

  task automatic ib(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      b_valid = 1'b0; b_sof = 1'b0;
    end
  endtask

  task automatic frame_a(input int off, input logic first_sof, input logic gaps);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 5; c++) begin
        if (gaps && $urandom_range(0, 1) == 1) ia(1);
        pa(off + r * 16 + c, first_sof && r == 0 && c == 0);
      end
  endtask

  task automatic seq_a(input string name, input int s, input int i0, input int n, input int off);
    for (int i = 0; i < n; i++) begin
      if (qa.size() > s + i0 + i) begin
        chk(name, qa[s + i0 + i].flat, win_at(off, i, 3));
        chk({name, "_row"}, 144'(qa[s + i0 + i].row), 144'(1 + i / 3));
        chk({name, "_col"}, 144'(qa[s + i0 + i].col), 144'(1 + i % 3));
      end
    end
  endtask

  initial begin
    int s, f;
    rst_n = 1'b0; chk_en = 1'b0;
    a_valid = 1'b0; a_sof = 1'b0; a_pix = '0;
    b_valid = 1'b0; b_sof = 1'b0; b_pix = '0;
    fork monitor(); join_none
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1; chk_en = 1'b1;
    chk("rst_win_valid",  144'(cfg[0].ifc.win_valid),  144'(0));
    chk("rst_frame_done", 144'(cfg[0].ifc.frame_done), 144'(0));
    chk("rst_window",     cfg[0].act_flat,             144'(0));

    // 1: one gapless frame
    s = qa.size(); f = nfd_a;
    frame_a(0, 1'b1, 1'b0); ia(3);
    chk("t1_count", 144'(qa.size() - s), 144'(6));
    chk("t1_fd",    144'(nfd_a - f),     144'(1));
    if (qa.size() >= s + 6) begin
      chk("t1_first",     qa[s].flat, 144'h0000_0001_0002_0010_0011_0012_0020_0021_0022);
      chk("t1_first_row", 144'(qa[s].row), 144'(1));
      chk("t1_first_col", 144'(qa[s].col), 144'(1));
      chk("t1_last_win8", 144'(qa[s + 5].flat[15:0]), 144'h34);
      chk("t1_last_fd",   144'(qa[s + 5].fd), 144'(1));
      chk("t1_last_row",  144'(qa[s + 5].row), 144'(2));
      chk("t1_last_col",  144'(qa[s + 5].col), 144'(3));
    end

    // 2: same frame with random gaps
    s = qa.size(); f = nfd_a;
    frame_a(0, 1'b1, 1'b1); ia(3);
    chk("t2_count", 144'(qa.size() - s), 144'(6));
    chk("t2_fd",    144'(nfd_a - f),     144'(1));
    seq_a("t2_win", s, 0, 6, 0);

    // 3: back-to-back frames, second without sof
    s = qa.size(); f = nfd_a;
    frame_a(0, 1'b1, 1'b0); frame_a(16'h100, 1'b0, 1'b0); ia(3);
    chk("t3_count", 144'(qa.size() - s), 144'(12));
    chk("t3_fd",    144'(nfd_a - f),     144'(2));
    seq_a("t3_win_f1", s, 0, 6, 0);
    seq_a("t3_win_f2", s, 6, 6, 16'h100);

    // 4: sof at pixel (2,1) aborts the frame
    s = qa.size(); f = nfd_a;
    for (int p = 0; p < 11; p++) pa((p / 5) * 16 + p % 5, p == 0);
    frame_a(16'h200, 1'b1, 1'b0); ia(3);
    chk("t4_count", 144'(qa.size() - s), 144'(6));
    chk("t4_fd",    144'(nfd_a - f),     144'(1));
    seq_a("t4_win", s, 0, 6, 16'h200);

    // 5: reset after pixel (3,1), then a frame without sof
    for (int p = 0; p < 17; p++) pa(16'h300 + (p / 5) * 16 + p % 5, p == 0);
    @(posedge clk); #1; rst_n = 1'b0; a_valid = 1'b0; a_sof = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    chk("t5_rst_valid",  144'(cfg[0].ifc.win_valid),  144'(0));
    chk("t5_rst_fd",     144'(cfg[0].ifc.frame_done), 144'(0));
    chk("t5_rst_row",    144'(cfg[0].ifc.win_row),    144'(0));
    chk("t5_rst_col",    144'(cfg[0].ifc.win_col),    144'(0));
    chk("t5_rst_window", cfg[0].act_flat,             144'(0));
    s = qa.size(); f = nfd_a;
    frame_a(16'h300, 1'b0, 1'b0); ia(3);
    chk("t5_count", 144'(qa.size() - s), 144'(6));
    chk("t5_fd",    144'(nfd_a - f),     144'(1));
    seq_a("t5_win", s, 0, 6, 16'h300);

    // 6: minimum 3x3 image
    s = qb.size(); f = nfd_b;
    for (int p = 0; p < 9; p++) pb(p + 1, p == 0);
    ib(3);
    chk("t6_count", 144'(qb.size() - s), 144'(1));
    chk("t6_fd",    144'(nfd_b - f),     144'(1));
    if (qb.size() > s) begin
      chk("t6_window", qb[s].flat, 144'h0001_0002_0003_0004_0005_0006_0007_0008_0009);
      chk("t6_row",    144'(qb[s].row), 144'(1));
      chk("t6_col",    144'(qb[s].col), 144'(1));
      chk("t6_win_fd", 144'(qb[s].fd),  144'(1));
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
